// File: rtl/regfile_dump_if.sv
// rtl/regfile_dump_if.sv - control, register-file read port and beat stream of the register dump engine
interface regfile_dump_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] first_reg;
    logic [ADDR_W-1:0] last_reg;
    logic              abort;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_index;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    modport slave (
        input  start, first_reg, last_reg, abort, rf_data, out_ready,
        output rf_addr, out_valid, out_index, out_data, out_last, busy, done
    );

    modport master (
        output start, first_reg, last_reg, abort, rf_data, out_ready,
        input  rf_addr, out_valid, out_index, out_data, out_last, busy, done
    );
endinterface

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - walks a register index range over a dedicated read port and streams (index, data) beats
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic           clk,
    input  logic           reset,
    regfile_dump_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] next_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            end_q     <= '0;
            rf_addr_q <= '0;
            valid_q   <= 1'b0;
            index_q   <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            end_q     <= end_d;
            rf_addr_q <= rf_addr_d;
            valid_q   <= valid_d;
            index_q   <= index_d;
            data_q    <= data_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        end_d     = end_q;
        rf_addr_d = rf_addr_q;
        valid_d   = valid_q;
        index_d   = index_q;
        data_d    = data_q;
        last_d    = last_q;
        next_idx  = (cur_q == LAST_IDX) ? '0 : cur_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cur_d     = bus.first_reg;
                    end_d     = bus.last_reg;
                    rf_addr_d = bus.first_reg;
                    state_d   = READ;
                end
            end
            READ: begin
                data_d  = bus.rf_data;
                index_d = cur_q;
                last_d  = (cur_q == end_q);
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (valid_q && bus.out_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = DONE;
                    end else begin
                        cur_d     = next_idx;
                        rf_addr_d = next_idx;
                        state_d   = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over a same-cycle acceptance and drops any presented beat.
        if (bus.abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            cur_d     = cur_q;
            rf_addr_d = rf_addr_q;
            index_d   = index_q;
            data_d    = data_q;
            valid_d   = 1'b0;
            last_d    = 1'b0;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign bus.rf_addr   = rf_addr_q;
    assign bus.out_valid = valid_q;
    assign bus.out_index = index_q;
    assign bus.out_data  = data_q;
    assign bus.out_last  = last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_regfile_dump.sv
// tb/tb_regfile_dump.sv - scoreboard bench for regfile_dump against a behavioural register file
module tb_regfile_dump;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_dump_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    regfile_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register file: clocked write port, combinational third read port.
    logic [31:0] rf [32];
    logic        we = 1'b0;
    logic [4:0]  wa = '0;
    logic [31:0] wd = '0;
    logic        preload = 1'b0;
    logic [31:0] exp_rf [32];

    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 32; k++) rf[k] <= 32'h1000_0000 + 32'(k);
        end else if (we) begin
            rf[wa] <= wd;
        end
    end
    assign bus.rf_data = rf[bus.rf_addr];

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t sb [$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_beats  = 0;
    int    n_done   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic  hold_v = 1'b0;
    beat_t hold_b;

    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("stall valid held", 64'(bus.out_valid), 64'd1);
                check("stall beat stable", 64'({bus.out_index, bus.out_data, bus.out_last}), 64'(hold_b));
            end
            if (bus.out_valid && bus.out_ready) begin
                n_beats++;
                hold_v = 1'b0;
                if (sb.size() == 0) begin
                    check("unexpected beat", 64'(bus.out_index), 64'hFFFF);
                end else begin
                    e = sb.pop_front();
                    check("beat index", 64'(bus.out_index), 64'(e.idx));
                    check("beat data", 64'(bus.out_data), 64'(e.data));
                    check("beat last", 64'(bus.out_last), 64'(e.last));
                end
            end else if (bus.out_valid) begin
                hold_v = 1'b1;
                hold_b = {bus.out_index, bus.out_data, bus.out_last};
            end else begin
                hold_v = 1'b0;
            end
            if (bus.done) n_done++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input logic [4:0] f, input logic [4:0] l);
        logic [4:0] i;
        beat_t b;
        i = f;
        for (int n = 0; n < 32; n++) begin
            b.idx  = i;
            b.data = exp_rf[i];
            b.last = (i == l);
            sb.push_back(b);
            if (i == l) break;
            i = i + 5'd1;
        end
    endtask

    task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
        bus.first_reg = f;
        bus.last_reg  = l;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    // Called in cycle 1 after start; exp_cyc > 0 also checks the cycle done shows up in.
    task automatic wait_done(input string tag, input int exp_cyc, input bit rnd);
        int cyc;
        cyc = 1;
        while (!bus.done && cyc < 400) begin
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        check({tag, " done seen"}, 64'(bus.done), 64'd1);
        if (exp_cyc > 0) check({tag, " done cycle"}, 64'(cyc), 64'(exp_cyc));
        bus.out_ready = 1'b1;
        tick();
        check({tag, " busy fell"}, 64'(bus.busy), 64'd0);
        check({tag, " sb drained"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int   d0, b0;
        beat_t b;
        bus.start = 1'b0; bus.first_reg = '0; bus.last_reg = '0;
        bus.abort = 1'b0; bus.out_ready = 1'b1;
        for (int k = 0; k < 32; k++) exp_rf[k] = 32'h1000_0000 + 32'(k);

        tick(); tick();
        check("rst rf_addr", 64'(bus.rf_addr), 64'd0);
        check("rst out_valid", 64'(bus.out_valid), 64'd0);
        check("rst out_index", 64'(bus.out_index), 64'd0);
        check("rst out_data", 64'(bus.out_data), 64'd0);
        check("rst out_last", 64'(bus.out_last), 64'd0);
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst done", 64'(bus.done), 64'd0);
        reset = 1'b0;
        preload = 1'b1; tick(); preload = 1'b0; tick();

        // Full range
        d0 = n_done; b0 = n_beats;
        push_range(5'd0, 5'd31);
        start_dump(5'd0, 5'd31);
        check("full busy rise", 64'(bus.busy), 64'd1);
        check("full rf_addr in read", 64'(bus.rf_addr), 64'd0);
        wait_done("full", 65, 1'b0);
        check("full beats", 64'(n_beats - b0), 64'd32);
        check("full done pulses", 64'(n_done - d0), 64'd1);

        // Wrapping range
        push_range(5'd30, 5'd2);
        b0 = n_beats;
        start_dump(5'd30, 5'd2);
        wait_done("wrap", 11, 1'b0);
        check("wrap beats", 64'(n_beats - b0), 64'd5);

        // Single beat under random stalls
        d0 = n_done;
        push_range(5'd9, 5'd9);
        start_dump(5'd9, 5'd9);
        wait_done("single", 0, 1'b1);
        check("single done pulses", 64'(n_done - d0), 64'd1);

        // Write landing the cycle before READ is seen
        b.idx = 5'd8; b.data = 32'hDEAD_BEEF; b.last = 1'b1;
        sb.push_back(b);
        we = 1'b1; wa = 5'd8; wd = 32'hDEAD_BEEF;
        start_dump(5'd8, 5'd8);
        we = 1'b0;
        wait_done("wr before", 3, 1'b0);

        // Write landing on the capture edge is not seen
        we = 1'b1; wd = 32'h1000_0008; tick(); we = 1'b0;
        b.data = 32'h1000_0008;
        sb.push_back(b);
        start_dump(5'd8, 5'd8);
        we = 1'b1; wd = 32'hDEAD_BEEF; tick(); we = 1'b0;
        wait_done("wr same edge", 0, 1'b0);
        exp_rf[8] = 32'hDEAD_BEEF;

        // Abort in SEND with simultaneous acceptance
        d0 = n_done;
        push_range(5'd0, 5'd31);
        start_dump(5'd0, 5'd31);
        for (int n = 0; n < 10 && !bus.out_valid; n++) tick();
        check("abort reached send", 64'(bus.out_valid), 64'd1);
        bus.abort = 1'b1; tick(); bus.abort = 1'b0;
        check("abort valid", 64'(bus.out_valid), 64'd0);
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort last", 64'(bus.out_last), 64'd0);
        sb.delete();
        for (int n = 0; n < 5; n++) tick();
        check("abort no done", 64'(n_done - d0), 64'd0);

        // Restart after abort; abort in IDLE alongside start must not block it
        push_range(5'd5, 5'd6);
        b0 = n_beats;
        bus.abort = 1'b1;
        start_dump(5'd5, 5'd6);
        bus.abort = 1'b0;
        wait_done("restart", 5, 1'b0);
        check("restart beats", 64'(n_beats - b0), 64'd2);

        // start while busy is ignored
        push_range(5'd3, 5'd5);
        b0 = n_beats;
        start_dump(5'd3, 5'd5);
        bus.first_reg = 5'd20; bus.last_reg = 5'd25;
        bus.start = 1'b1; tick(); tick(); tick(); bus.start = 1'b0;
        wait_done("busy start", 0, 1'b0);
        check("busy start beats", 64'(n_beats - b0), 64'd3);

        // Asynchronous reset between edges
        d0 = n_done;
        push_range(5'd0, 5'd31);
        start_dump(5'd0, 5'd31);
        for (int n = 0; n < 4; n++) tick();
        #2 reset = 1'b1;
        #1;
        b0 = n_beats;
        check("async rst rf_addr", 64'(bus.rf_addr), 64'd0);
        check("async rst valid", 64'(bus.out_valid), 64'd0);
        check("async rst index", 64'(bus.out_index), 64'd0);
        check("async rst data", 64'(bus.out_data), 64'd0);
        check("async rst last", 64'(bus.out_last), 64'd0);
        check("async rst busy", 64'(bus.busy), 64'd0);
        check("async rst done", 64'(bus.done), 64'd0);
        sb.delete();
        tick(); reset = 1'b0;
        for (int n = 0; n < 5; n++) tick();
        check("post rst valid", 64'(bus.out_valid), 64'd0);
        check("post rst beats", 64'(n_beats - b0), 64'd0);
        check("post rst no done", 64'(n_done - d0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
